// File: rtl/branch_resolve_unit_pkg.sv
// rtl/branch_resolve_unit_pkg.sv - branch codes, BPU update types and flush FSM states
package branch_resolve_unit_pkg;

   localparam logic [2:0] BC_BEQ = 3'd0;
   localparam logic [2:0] BC_BNE = 3'd1;
   localparam logic [2:0] BC_BGE = 3'd2;
   localparam logic [2:0] BC_BGT = 3'd3;
   localparam logic [2:0] BC_BLE = 3'd4;
   localparam logic [2:0] BC_BLT = 3'd5;
   localparam logic [2:0] BC_J   = 3'd6;
   localparam logic [2:0] BC_JR  = 3'd7;

   typedef enum logic [1:0] {
      BT_NONE = 2'd0,
      BT_IMME = 2'd1,
      BT_CALL = 2'd2,
      BT_RETN = 2'd3
   } bres_type_e;

   typedef enum logic [1:0] {
      ST_IDLE       = 2'd0,
      ST_REDIRECT   = 2'd1,
      ST_WAIT_FLUSH = 2'd2
   } bru_state_e;

   // Sign/zero tests treat opa as a signed value compared against zero.
   function automatic logic branch_taken(input logic [2:0] code, input logic a_neg,
                                         input logic a_zero, input logic a_eq_b);
      logic t;
      t = 1'b0;
      case (code)
         BC_BEQ:  t = a_eq_b;
         BC_BNE:  t = ~a_eq_b;
         BC_BGE:  t = ~a_neg;
         BC_BGT:  t = ~a_neg & ~a_zero;
         BC_BLE:  t = a_neg | a_zero;
         BC_BLT:  t = a_neg;
         default: t = 1'b1;
      endcase
      return t;
   endfunction

endpackage

// File: rtl/branch_resolve_unit_if.sv
// rtl/branch_resolve_unit_if.sv - EXE resolve inputs, redirect/BPU update and status outputs
interface branch_resolve_unit_if #(
   parameter int ADDR_W = 32,
   parameter int STAT_W = 32
);
   logic              ex_valid;
   logic              ex_stall;
   logic              ex_is_branch;
   logic [2:0]        ex_branch_code;
   logic              ex_is_call;
   logic [4:0]        ex_rs;
   logic [ADDR_W-1:0] ex_opa;
   logic [ADDR_W-1:0] ex_opb;
   logic [ADDR_W-1:0] ex_pc;
   logic [ADDR_W-1:0] ex_branch_addr;
   logic [ADDR_W-1:0] ex_jump_addr;
   logic              pred_valid;
   logic [ADDR_W-1:0] pred_target;
   logic              flush_ack;
   logic              redirect_valid;
   logic [ADDR_W-1:0] redirect_pc;
   logic              bres_valid;
   logic [ADDR_W-1:0] bres_pc;
   logic [ADDR_W-1:0] bres_target;
   logic              bres_taken;
   logic [1:0]        bres_type;
   logic              bres_mispred;
   logic [ADDR_W-1:0] ras_top;
   logic              ras_top_valid;
   logic              busy;
   logic [STAT_W-1:0] stat_branches;
   logic [STAT_W-1:0] stat_mispred;

   modport master (
      output ex_valid, ex_stall, ex_is_branch, ex_branch_code, ex_is_call, ex_rs,
             ex_opa, ex_opb, ex_pc, ex_branch_addr, ex_jump_addr,
             pred_valid, pred_target, flush_ack,
      input  redirect_valid, redirect_pc, bres_valid, bres_pc, bres_target, bres_taken,
             bres_type, bres_mispred, ras_top, ras_top_valid, busy,
             stat_branches, stat_mispred
   );

   modport slave (
      input  ex_valid, ex_stall, ex_is_branch, ex_branch_code, ex_is_call, ex_rs,
             ex_opa, ex_opb, ex_pc, ex_branch_addr, ex_jump_addr,
             pred_valid, pred_target, flush_ack,
      output redirect_valid, redirect_pc, bres_valid, bres_pc, bres_target, bres_taken,
             bres_type, bres_mispred, ras_top, ras_top_valid, busy,
             stat_branches, stat_mispred
   );
endinterface

// File: rtl/branch_resolve_unit_ras_stack.sv
// rtl/branch_resolve_unit_ras_stack.sv - committed return-address stack (bru_ras_stack)
// Circular buffer: a push when full overwrites the oldest entry, a pop when empty is ignored.
module bru_ras_stack #(
   parameter int ADDR_W = 32,
   parameter int DEPTH  = 8,
   parameter int PTR_W  = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              push,
   input  logic              pop,
   input  logic [ADDR_W-1:0] push_data,
   output logic [ADDR_W-1:0] top,
   output logic              top_valid
);
   localparam logic [PTR_W:0] CNT_FULL = (PTR_W+1)'(DEPTH);

   logic [ADDR_W-1:0] mem_q [DEPTH];
   logic [ADDR_W-1:0] mem_d [DEPTH];
   logic [PTR_W-1:0]  ptr_q, ptr_d;
   logic [PTR_W:0]    cnt_q, cnt_d;

   always_comb begin
      mem_d = mem_q;
      ptr_d = ptr_q;
      cnt_d = cnt_q;
      if (push) begin
         mem_d[ptr_q] = push_data;
         ptr_d        = ptr_q + PTR_W'(1);
         if (cnt_q != CNT_FULL) cnt_d = cnt_q + (PTR_W+1)'(1);
      end else if (pop && cnt_q != '0) begin
         ptr_d = ptr_q - PTR_W'(1);
         cnt_d = cnt_q - (PTR_W+1)'(1);
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         ptr_q <= '0;
         cnt_q <= '0;
      end else begin
         mem_q <= mem_d;
         ptr_q <= ptr_d;
         cnt_q <= cnt_d;
      end
   end

   // ptr points at the next free slot, so the top lives one below it.
   assign top       = mem_q[ptr_q - PTR_W'(1)];
   assign top_valid = (cnt_q != '0);

endmodule

// File: rtl/branch_resolve_unit.sv
// rtl/branch_resolve_unit.sv - registered EXE branch resolver with flush handshake and committed RAS
// Optional statistics counters are built only when BRANCH_STAT_EN is defined.
module branch_resolve_unit
   import branch_resolve_unit_pkg::*;
#(
   parameter int ADDR_W    = 32,
   parameter int RAS_DEPTH = 8,
   parameter int RAS_PTR_W = $clog2(RAS_DEPTH),
   parameter int STAT_W    = 32
) (
   input logic                  clk,
   input logic                  resetn,
   branch_resolve_unit_if.slave bus
);
   bru_state_e        state_q, state_d;
   logic              fire;
   logic [ADDR_W-1:0] pc_plus8;
   logic              act_taken;
   logic [ADDR_W-1:0] act_target;
   logic [1:0]        act_type;
   logic              act_mispred;

   logic              bres_valid_q, bres_valid_d;
   logic [ADDR_W-1:0] bres_pc_q, bres_pc_d;
   logic [ADDR_W-1:0] bres_target_q, bres_target_d;
   logic              bres_taken_q, bres_taken_d;
   logic [1:0]        bres_type_q, bres_type_d;
   logic              bres_mispred_q, bres_mispred_d;
   logic [ADDR_W-1:0] redirect_pc_q, redirect_pc_d;

   assign fire     = bus.ex_valid & ~bus.ex_stall & (state_q == ST_IDLE);
   assign pc_plus8 = bus.ex_pc + ADDR_W'(8);

   always_comb begin
      act_taken  = 1'b0;
      act_target = pc_plus8;
      act_type   = BT_NONE;
      if (bus.ex_is_branch) begin
         act_taken = branch_taken(bus.ex_branch_code, bus.ex_opa[ADDR_W-1],
                                  bus.ex_opa == '0, bus.ex_opa == bus.ex_opb);
         case (bus.ex_branch_code)
            BC_J: begin
               act_target = bus.ex_jump_addr;
               act_type   = bus.ex_is_call ? BT_CALL : BT_IMME;
            end
            BC_JR: begin
               act_target = bus.ex_opa;
               act_type   = (!bus.ex_is_call && bus.ex_rs == 5'd31) ? BT_RETN : BT_IMME;
            end
            default: begin
               act_target = act_taken ? bus.ex_branch_addr : pc_plus8;
               act_type   = BT_IMME;
            end
         endcase
      end
      act_mispred = bus.pred_valid & (bus.pred_target != act_target);
   end

   always_comb begin
      bres_valid_d   = fire;
      bres_pc_d      = bres_pc_q;
      bres_target_d  = bres_target_q;
      bres_taken_d   = bres_taken_q;
      bres_type_d    = bres_type_q;
      bres_mispred_d = bres_mispred_q;
      if (fire) begin
         bres_pc_d      = bus.ex_pc;
         bres_target_d  = act_target;
         bres_taken_d   = act_taken;
         bres_type_d    = act_type;
         bres_mispred_d = act_mispred;
      end
   end

   always_comb begin
      state_d       = state_q;
      redirect_pc_d = redirect_pc_q;
      case (state_q)
         ST_IDLE: begin
            if (fire && act_mispred) begin
               state_d       = ST_REDIRECT;
               redirect_pc_d = act_target;
            end
         end
         ST_REDIRECT:   state_d = bus.flush_ack ? ST_IDLE : ST_WAIT_FLUSH;
         ST_WAIT_FLUSH: if (bus.flush_ack) state_d = ST_IDLE;
         default:       state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q        <= ST_IDLE;
         bres_valid_q   <= 1'b0;
         bres_pc_q      <= '0;
         bres_target_q  <= '0;
         bres_taken_q   <= 1'b0;
         bres_type_q    <= BT_NONE;
         bres_mispred_q <= 1'b0;
         redirect_pc_q  <= '0;
      end else begin
         state_q        <= state_d;
         bres_valid_q   <= bres_valid_d;
         bres_pc_q      <= bres_pc_d;
         bres_target_q  <= bres_target_d;
         bres_taken_q   <= bres_taken_d;
         bres_type_q    <= bres_type_d;
         bres_mispred_q <= bres_mispred_d;
         redirect_pc_q  <= redirect_pc_d;
      end
   end

   assign bus.bres_valid     = bres_valid_q;
   assign bus.bres_pc        = bres_pc_q;
   assign bus.bres_target    = bres_target_q;
   assign bus.bres_taken     = bres_taken_q;
   assign bus.bres_type      = bres_type_q;
   assign bus.bres_mispred   = bres_mispred_q;
   assign bus.redirect_valid = (state_q == ST_REDIRECT);
   assign bus.redirect_pc    = redirect_pc_q;
   assign bus.busy           = (state_q != ST_IDLE);

   bru_ras_stack #(
      .ADDR_W (ADDR_W),
      .DEPTH  (RAS_DEPTH),
      .PTR_W  (RAS_PTR_W)
   ) u_ras (
      .clk       (clk),
      .resetn    (resetn),
      .push      (fire && act_type == BT_CALL),
      .pop       (fire && act_type == BT_RETN),
      .push_data (pc_plus8),
      .top       (bus.ras_top),
      .top_valid (bus.ras_top_valid)
   );

`ifdef BRANCH_STAT_EN
   logic [STAT_W-1:0] stat_br_q, stat_br_d;
   logic [STAT_W-1:0] stat_mp_q, stat_mp_d;

   always_comb begin
      stat_br_d = stat_br_q;
      stat_mp_d = stat_mp_q;
      if (fire && bus.ex_is_branch) stat_br_d = stat_br_q + STAT_W'(1);
      if (fire && act_mispred)      stat_mp_d = stat_mp_q + STAT_W'(1);
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         stat_br_q <= '0;
         stat_mp_q <= '0;
      end else begin
         stat_br_q <= stat_br_d;
         stat_mp_q <= stat_mp_d;
      end
   end

   assign bus.stat_branches = stat_br_q;
   assign bus.stat_mispred  = stat_mp_q;
`else
   assign bus.stat_branches = '0;
   assign bus.stat_mispred  = '0;
`endif

endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
- Parametrised successor to the EXE-stage branch resolver.
- Resolves the actual direction, target and type of every branch in EXE, and compares them with the prediction carried down the pipeline.
- Unlike the combinational version, it registers the redirect and the BPU update, and runs a flush-handshake FSM that squashes wrong-path resolves.
- Owns a committed return-address stack (RAS) whose top is exported for front-end RAS repair.

Parameters:
- ADDR_W, 32: width of PC, operands and targets.
- RAS_DEPTH, 8: RAS entries; must be a power of 2, ≥2.
- RAS_PTR_W, $clog2(RAS_DEPTH): RAS pointer width (derived).
- STAT_W, 32: width of the statistics counters.

Ports:
- clk  in  1  clock
- resetn  in  1  asynchronous, active-low reset
- ex_valid  in  1  EXE holds a valid instruction
- ex_stall  in  1  EXE stalled this cycle
- ex_is_branch  in  1  instruction is a branch or jump
- ex_branch_code  in  3  BEQ/BNE/BGE/BGT/BLE/BLT/J/JR
- ex_is_call  in  1  JAL/JALR
- ex_rs  in  5  rs index
- ex_opa, ex_opb  in  ADDR_W  forwarded operands
- ex_pc  in  ADDR_W  instruction PC
- ex_branch_addr, ex_jump_addr  in  ADDR_W  precomputed targets
- pred_valid  in  1  a prediction accompanies the instruction
- pred_target  in  ADDR_W  predicted next-fetch address
- flush_ack  in  1  front end has completed the flush
- redirect_valid  out  1  one-cycle redirect pulse
- redirect_pc  out  ADDR_W  corrected fetch address
- bres_valid  out  1  BPU update pulse
- bres_pc, bres_target  out  ADDR_W  update PC and actual target
- bres_taken  out  1  actual direction
- bres_type  out  2  NONE/IMME/CALL/RETN
- bres_mispred  out  1  prediction failed
- ras_top  out  ADDR_W  committed RAS top entry
- ras_top_valid  out  1  RAS is non-empty
- busy  out  1  FSM is not in IDLE
- stat_branches, stat_mispred  out  STAT_W  statistics counters

Behaviour:
- Reset (asynchronous, any time, including mid-flush): FSM returns to IDLE. RAS pointer and count go to 0. Every output goes to 0.
- Resolve fire: fire = ex_valid & ~ex_stall & (state==IDLE).
  - Resolves arriving in REDIRECT or WAIT_FLUSH are wrong-path. They are dropped: no bres, no RAS change, no counter change.
- Direction rules:
  - BEQ: a==b. BNE: a!=b. BGE: ~a[MSB]. BGT: ~a[MSB] & a!=0. BLE: a[MSB] | a==0. BLT: a[MSB].
  - J and JR: always taken.
  - Non-branch: not taken.
- Target rules:
  - J: jump_addr. JR: opa.
  - Conditional branch: taken → branch_addr, otherwise pc+8.
  - Non-branch: pc+8.
  - pc+8 is computed internally, modulo 2^ADDR_W.
- Type rules:
  - J with call → CALL. J without call → IMME.
  - JR with call → IMME. JR without call and rs==31 → RETN. Other JR → IMME.
  - Conditional branch → IMME. Non-branch → NONE.
- Mispredict = pred_valid & (pred_target != actual target).
- Latency: the bres_* outputs are registered. On the cycle after a fire, bres_valid pulses with the values of that fire; otherwise bres_valid=0.
- FSM:
  - IDLE: a fire that mispredicts goes to REDIRECT.
  - REDIRECT: lasts exactly one cycle; redirect_valid=1 and redirect_pc = actual target. Goes to IDLE if flush_ack is high this cycle, otherwise to WAIT_FLUSH.
  - WAIT_FLUSH: stays until flush_ack, then goes to IDLE.
  - flush_ack seen in IDLE is ignored.
  - busy = (state != IDLE).
- RAS (updated on fire only):
  - CALL pushes pc+8. RETN pops. No other type touches the RAS.
  - Push when full overwrites the oldest entry: pointer wraps, count saturates at RAS_DEPTH.
  - Pop when empty: no change.
  - ras_top and ras_top_valid are registered and reflect the state after the update.

Optional Feature:
- BRANCH_STAT_EN defined:
  - stat_branches increments on every fire with ex_is_branch=1.
  - stat_mispred increments on every fire that mispredicts.
  - Both wrap at 2^STAT_W and clear on reset.
- BRANCH_STAT_EN undefined: both stat ports are constant 0 and no counter flops are synthesised.

Decomposition:
- Shared package holds:
  - branch-code constants
  - the 2-bit bres_type encodings (NONE=0, IMME=1, CALL=2, RETN=3)
  - the FSM state enum (IDLE, REDIRECT, WAIT_FLUSH)
- One sub-module, bru_ras_stack: circular buffer, pointer/count logic, and push/pop/top.

Test Plan:
- BEQ, a=b=0x5, pc=0x100, branch_addr=0x140, pred_target=0x108 → next cycle bres_taken=1, bres_target=0x140, bres_mispred=1; redirect_valid pulses for one cycle with redirect_pc=0x140.
- Same mispredict with flush_ack held low for 3 cycles, resolves presented meanwhile → bres_valid stays 0 and busy=1 until flush_ack; IDLE on the following cycle.
- JAL at pc=0x200 → ras_top=0x208, ras_top_valid=1. Then JR with rs=31 and opa=0x208, pred_target=0x208 → bres_type=RETN, no redirect, ras_top_valid=0.
- 9 pushes with RAS_DEPTH=8 (pc 0x0,0x10…0x80) → ras_top=0x88. After 8 pops ras_top_valid=0. A 9th pop leaves the RAS unchanged.
- BLT with opa=0x80000000 and pred_valid=0 → bres_taken=1, no redirect. ex_stall=1 with valid → no bres_valid.
- resetn asserted low during WAIT_FLUSH → immediately busy=0, redirect_valid=0, ras_top_valid=0; with BRANCH_STAT_EN, stat_branches=0.
